// File: rtl/fml_arb4_if.sv
// One FML burst port: master drives address/request/write data, slave returns ack and read data.
interface fml_arb4_if #(
   parameter int sdram_depth = 26
);
   logic [sdram_depth-1:0] adr;
   logic                   stb;
   logic                   we;
   logic                   ack;
   logic [3:0]             sel;
   logic [31:0]            di;
   logic [31:0]            dout;

   modport master (output adr, stb, we, sel, di, input ack, dout);
   modport slave  (input adr, stb, we, sel, di, output ack, dout);
endinterface

// File: rtl/fml_arb4.sv
// Four-master round-robin arbiter in front of the SDRAM controller's single FML port.
// Ownership is held from grant until the last of the four burst beats.
module fml_arb4 #(
   parameter int sdram_depth = 26
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   fml_arb4_if.slave  m0,
   fml_arb4_if.slave  m1,
   fml_arb4_if.slave  m2,
   fml_arb4_if.slave  m3,
   fml_arb4_if.master s
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                 state, state_next;
   logic [1:0]             owner, owner_next;
   logic [1:0]             last, last_next;
   logic [1:0]             beat_cnt, beat_cnt_next;
   logic [sdram_depth-1:0] adr_q, adr_next;
   logic                   we_q, we_next;

   logic [3:0]             req;
   logic [3:0]             m_we;
   logic [sdram_depth-1:0] m_adr [4];
   logic [3:0]             m_sel [4];
   logic [31:0]            m_di  [4];
   logic [1:0]             pick;
   logic [3:0]             ack_vec;

   assign req      = {m3.stb, m2.stb, m1.stb, m0.stb};
   assign m_we     = {m3.we, m2.we, m1.we, m0.we};
   assign m_adr[0] = m0.adr;
   assign m_adr[1] = m1.adr;
   assign m_adr[2] = m2.adr;
   assign m_adr[3] = m3.adr;
   assign m_sel[0] = m0.sel;
   assign m_sel[1] = m1.sel;
   assign m_sel[2] = m2.sel;
   assign m_sel[3] = m3.sel;
   assign m_di[0]  = m0.di;
   assign m_di[1]  = m1.di;
   assign m_di[2]  = m2.di;
   assign m_di[3]  = m3.di;

   // Scanning from the far end lets the nearest requester after 'last' win.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
      logic [1:0] idx;
      rr_pick = l;
      for (int k = 4; k >= 1; k--) begin
         idx = l + 2'(k);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   assign pick = rr_pick(req, last);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         owner    <= 2'd0;
         last     <= 2'd3;
         beat_cnt <= 2'd0;
         adr_q    <= '0;
         we_q     <= 1'b0;
      end else begin
         state    <= state_next;
         owner    <= owner_next;
         last     <= last_next;
         beat_cnt <= beat_cnt_next;
         adr_q    <= adr_next;
         we_q     <= we_next;
      end
   end

   always_comb begin
      state_next    = state;
      owner_next    = owner;
      last_next     = last;
      beat_cnt_next = beat_cnt;
      adr_next      = adr_q;
      we_next       = we_q;
      case (state)
         IDLE: begin
            if (|req) begin
               owner_next = pick;
               last_next  = pick;
               adr_next   = m_adr[pick];
               we_next    = m_we[pick];
               state_next = ADDR;
            end
         end
         ADDR: begin
            // A request withdrawn before the controller acks is dropped; 'last' keeps the grant.
            if (s.ack) begin
               beat_cnt_next = 2'd3;
               state_next    = DATA;
            end else if (!req[owner]) begin
               state_next = IDLE;
            end
         end
         DATA: begin
            beat_cnt_next = beat_cnt - 2'd1;
            if (beat_cnt == 2'd1) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign ack_vec = (state == ADDR && s.ack) ? (4'b0001 << owner) : 4'b0000;

   assign s.stb = (state == ADDR);
   assign s.adr = adr_q;
   assign s.we  = we_q;
   assign s.sel = m_sel[owner];
   assign s.di  = m_di[owner];

   assign m0.ack  = ack_vec[0];
   assign m1.ack  = ack_vec[1];
   assign m2.ack  = ack_vec[2];
   assign m3.ack  = ack_vec[3];
   assign m0.dout = s.dout;
   assign m1.dout = s.dout;
   assign m2.dout = s.dout;
   assign m3.dout = s.dout;

endmodule

// File: tb/tb_fml_arb4.sv
// Bench for fml_arb4: directed scenarios plus random traffic, all checked against a
// transaction-level model of the shared port.
module tb_fml_arb4;

   localparam int PH_FREE = 0;
   localparam int PH_ADDR = 1;
   localparam int PH_DATA = 2;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [3:0]  m_stb;
   logic [3:0]  m_we;
   logic [25:0] m_adr [4];
   logic [3:0]  m_sel [4];
   logic [31:0] m_di  [4];
   logic        s_ack;
   logic [31:0] s_do;
   logic [3:0]  m_ack;
   logic [31:0] m_do  [4];

   int n_compared   = 0;
   int n_mismatched = 0;

   int          mdl_phase;
   int          mdl_owner;
   int          mdl_last;
   int          mdl_left;
   logic [25:0] mdl_adr;
   logic        mdl_we;

   int          obs_ack [4];
   logic [3:0]  last_ack;
   int          ack_wait;
   int          obs_grants [$];
   logic        prev_stb;

   fml_arb4_if #(.sdram_depth(26)) m_if [4] ();
   fml_arb4_if #(.sdram_depth(26)) s_if ();

   for (genvar g = 0; g < 4; g++) begin : g_m
      assign m_if[g].adr = m_adr[g];
      assign m_if[g].stb = m_stb[g];
      assign m_if[g].we  = m_we[g];
      assign m_if[g].sel = m_sel[g];
      assign m_if[g].di  = m_di[g];
      assign m_ack[g]    = m_if[g].ack;
      assign m_do[g]     = m_if[g].dout;
   end

   assign s_if.ack  = s_ack;
   assign s_if.dout = s_do;

   fml_arb4 #(.sdram_depth(26)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .m0        (m_if[0]),
      .m1        (m_if[1]),
      .m2        (m_if[2]),
      .m3        (m_if[3]),
      .s         (s_if)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mdl_phase = PH_FREE;
      mdl_owner = 0;
      mdl_last  = 3;
      mdl_left  = 0;
      mdl_adr   = '0;
      mdl_we    = 1'b0;
   endtask

   // Port-level behaviour: who holds the port and for how many more cycles.
   task automatic model_step();
      case (mdl_phase)
         PH_FREE: begin
            for (int k = 1; k <= 4; k++) begin
               int c;
               c = (mdl_last + k) % 4;
               if (m_stb[c]) begin
                  mdl_owner = c;
                  mdl_last  = c;
                  mdl_adr   = m_adr[c];
                  mdl_we    = m_we[c];
                  mdl_phase = PH_ADDR;
                  break;
               end
            end
         end
         PH_ADDR: begin
            if (s_ack) begin
               mdl_phase = PH_DATA;
               mdl_left  = 3;
            end else if (!m_stb[mdl_owner]) begin
               mdl_phase = PH_FREE;
            end
         end
         default: begin
            mdl_left--;
            if (mdl_left == 0) mdl_phase = PH_FREE;
         end
      endcase
   endtask

   task automatic check_cycle();
      logic [3:0] exp_ack;
      exp_ack = (mdl_phase == PH_ADDR && s_ack) ? 4'(4'b0001 << mdl_owner) : 4'b0000;
      check_output("s_stb", 32'(s_if.stb), 32'(mdl_phase == PH_ADDR));
      check_output("s_adr", 32'(s_if.adr), 32'(mdl_adr));
      check_output("s_we", 32'(s_if.we), 32'(mdl_we));
      check_output("m_ack", 32'(m_ack), 32'(exp_ack));
      check_output("s_di", s_if.di, m_di[mdl_owner]);
      check_output("s_sel", 32'(s_if.sel), 32'(m_sel[mdl_owner]));
      for (int i = 0; i < 4; i++) check_output("m_do", m_do[i], s_do);
   endtask

   task automatic sample_cycle();
      @(negedge sys_clk);
      check_cycle();
      for (int i = 0; i < 4; i++) obs_ack[i] += int'(m_ack[i]);
      last_ack = m_ack;
   endtask

   task automatic advance_clock();
      @(posedge sys_clk);
      if (sys_rst_n) model_step();
      #1;
   endtask

   task automatic run_cycle();
      sample_cycle();
      advance_clock();
   endtask

   task automatic clear_acks();
      for (int i = 0; i < 4; i++) obs_ack[i] = 0;
   endtask

   // Random masters and controller; requests held until acked, occasional aborts.
   task automatic apply_stimulus();
      s_do = $urandom;
      for (int i = 0; i < 4; i++) begin
         m_di[i]  = $urandom;
         m_sel[i] = 4'($urandom);
      end
      if (s_if.stb) begin
         if (ack_wait == 0) begin
            s_ack    = 1'b1;
            ack_wait = $urandom_range(0, 3);
         end else begin
            s_ack = 1'b0;
            ack_wait--;
         end
      end else begin
         s_ack = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         if (last_ack[i]) begin
            m_stb[i] = 1'b0;
         end else if (!m_stb[i]) begin
            if ($urandom_range(0, 3) == 0) begin
               m_stb[i] = 1'b1;
               m_adr[i] = 26'($urandom);
               m_we[i]  = 1'($urandom);
            end
         end else if (mdl_phase == PH_ADDR && mdl_owner == i && !s_ack
                      && $urandom_range(0, 19) == 0) begin
            m_stb[i] = 1'b0;
         end
      end
   endtask

   initial begin
      sys_rst_n = 1'b0;
      m_stb     = '0;
      m_we      = '0;
      s_ack     = 1'b0;
      s_do      = 32'h5A5A_0001;
      ack_wait  = 0;
      last_ack  = '0;
      prev_stb  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_adr[i] = '0;
         m_sel[i] = '0;
         m_di[i]  = '0;
      end
      model_reset();
      clear_acks();

      repeat (2) @(negedge sys_clk);
      check_output("rst_s_stb", 32'(s_if.stb), 32'd0);
      check_output("rst_s_adr", 32'(s_if.adr), 32'd0);
      check_output("rst_s_we", 32'(s_if.we), 32'd0);
      check_output("rst_m_ack", 32'(m_ack), 32'd0);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      run_cycle();

      $display("[TB] lone m2 write burst");
      m_adr[2] = 26'h0001000;
      m_we[2]  = 1'b1;
      m_sel[2] = 4'hF;
      m_di[2]  = 32'hA0;
      m_stb[2] = 1'b1;
      run_cycle();
      sample_cycle();
      check_output("t1_stb", 32'(s_if.stb), 32'd1);
      check_output("t1_adr", 32'(s_if.adr), 32'h0001000);
      check_output("t1_we", 32'(s_if.we), 32'd1);
      advance_clock();
      repeat (3) run_cycle();
      s_ack = 1'b1;
      sample_cycle();
      check_output("t1_ack", 32'(m_ack), 32'h4);
      check_output("t1_beat0", s_if.di, 32'hA0);
      advance_clock();
      s_ack    = 1'b0;
      m_stb[2] = 1'b0;
      for (int b = 1; b < 4; b++) begin
         m_di[2] = 32'hA0 + 32'(b);
         sample_cycle();
         check_output("t1_beat", s_if.di, 32'hA0 + 32'(b));
         check_output("t1_stb_low", 32'(s_if.stb), 32'd0);
         advance_clock();
      end
      run_cycle();
      check_output("t1_m2_acks", 32'(obs_ack[2]), 32'd1);
      check_output("t1_other_acks", 32'(obs_ack[0] + obs_ack[1] + obs_ack[3]), 32'd0);

      $display("[TB] m1 abort in address phase");
      clear_acks();
      m_adr[1] = 26'h0002222;
      m_we[1]  = 1'b0;
      m_stb[1] = 1'b1;
      run_cycle();
      sample_cycle();
      check_output("abort_stb", 32'(s_if.stb), 32'd1);
      check_output("abort_adr", 32'(s_if.adr), 32'h0002222);
      advance_clock();
      m_stb[1] = 1'b0;
      run_cycle();
      sample_cycle();
      check_output("abort_stb_low", 32'(s_if.stb), 32'd0);
      advance_clock();
      check_output("abort_no_ack", 32'(obs_ack[1]), 32'd0);

      $display("[TB] m1 and m3 together after last grant to m1");
      m_adr[1] = 26'h0001111;
      m_adr[3] = 26'h0003333;
      m_stb[1] = 1'b1;
      m_stb[3] = 1'b1;
      run_cycle();
      sample_cycle();
      check_output("prio_first", 32'(s_if.adr), 32'h0003333);
      advance_clock();
      s_ack = 1'b1;
      sample_cycle();
      check_output("prio_ack3", 32'(m_ack), 32'h8);
      advance_clock();
      s_ack    = 1'b0;
      m_stb[3] = 1'b0;
      repeat (3) run_cycle();
      run_cycle();
      sample_cycle();
      check_output("prio_second", 32'(s_if.adr), 32'h0001111);
      advance_clock();
      s_ack = 1'b1;
      run_cycle();
      s_ack    = 1'b0;
      m_stb[1] = 1'b0;
      repeat (4) run_cycle();

      $display("[TB] m1 request arrives during m0 data phase");
      m_adr[0] = 26'h0000400;
      m_adr[1] = 26'h0000500;
      m_stb[0] = 1'b1;
      run_cycle();
      s_ack = 1'b1;
      run_cycle();
      s_ack    = 1'b0;
      m_stb[0] = 1'b0;
      run_cycle();
      m_stb[1] = 1'b1;
      run_cycle();
      run_cycle();
      sample_cycle();
      check_output("late_wait", 32'(s_if.stb), 32'd0);
      advance_clock();
      sample_cycle();
      check_output("late_grant", 32'(s_if.stb), 32'd1);
      check_output("late_adr", 32'(s_if.adr), 32'h0000500);
      advance_clock();
      s_ack = 1'b1;
      run_cycle();
      s_ack    = 1'b0;
      m_stb[1] = 1'b0;
      repeat (4) run_cycle();

      $display("[TB] reset during data beat 2");
      m_adr[0] = 26'h0000A00;
      m_we[0]  = 1'b1;
      m_stb[0] = 1'b1;
      run_cycle();
      s_ack = 1'b1;
      run_cycle();
      s_ack    = 1'b0;
      m_stb[0] = 1'b0;
      run_cycle();
      sys_rst_n = 1'b0;
      model_reset();
      #1;
      check_output("rst_mid_ack", 32'(m_ack), 32'd0);
      check_output("rst_mid_stb", 32'(s_if.stb), 32'd0);
      check_output("rst_mid_we", 32'(s_if.we), 32'd0);
      check_output("rst_mid_adr", 32'(s_if.adr), 32'd0);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      m_adr[3]  = 26'h0003030;
      m_stb[3]  = 1'b1;
      run_cycle();
      sample_cycle();
      check_output("post_rst_stb", 32'(s_if.stb), 32'd1);
      check_output("post_rst_adr", 32'(s_if.adr), 32'h0003030);
      advance_clock();
      s_ack = 1'b1;
      run_cycle();
      s_ack    = 1'b0;
      m_stb[3] = 1'b0;
      repeat (4) run_cycle();

      $display("[TB] all four masters reading continuously");
      for (int i = 0; i < 4; i++) begin
         m_adr[i] = 26'h100 * 26'(i + 1);
         m_we[i]  = 1'b0;
         m_stb[i] = 1'b1;
      end
      prev_stb = 1'b0;
      for (int c = 0; c < 100 && obs_grants.size() < 6; c++) begin
         s_ack = s_if.stb;
         sample_cycle();
         if (s_if.stb && !prev_stb) obs_grants.push_back(int'(s_if.adr >> 8) - 1);
         prev_stb = s_if.stb;
         advance_clock();
      end
      check_output("rr_count", 32'(obs_grants.size() >= 6), 32'd1);
      for (int k = 0; k < obs_grants.size() && k < 6; k++)
         check_output("rr_order", 32'(obs_grants[k]), 32'(k % 4));
      m_stb = '0;
      s_ack = 1'b0;
      repeat (6) run_cycle();

      $display("[TB] random traffic");
      last_ack = '0;
      repeat (2000) begin
         apply_stimulus();
         run_cycle();
      end
      m_stb = '0;
      s_ack = 1'b0;
      repeat (8) run_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/fml_arb4.md
# fml_arb4

Four-master round-robin arbiter sharing the single FML burst port of the DDR SDRAM controller between the CPU instruction cache, CPU data cache, GNSS sample DMA and a spare master. Each master sees a private FML port. The arbiter holds ownership of the port for the whole 4-beat burst, including address, write-data, byte-select and acknowledge routing. Read data is broadcast to all masters.

## Interface
- `sdram_depth`, 26, width of the FML byte address in bits; matches the memory controller.
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst_n`  in  1  asynchronous reset, active-low.
- `mN_adr`  in  sdram_depth  master N burst address, N = 0..3.
- `mN_stb`  in  1  master N request; held until `mN_ack`.
- `mN_we`  in  1  master N write when 1.
- `mN_ack`  out  1  master N acknowledge; marks the first data beat.
- `mN_sel`  in  4  master N byte enables for write beats.
- `mN_di`  in  32  master N write data.
- `m_do`  out  32  read data broadcast to all masters; equals `s_do`.
- `s_adr`  out  sdram_depth  address to the controller.
- `s_stb`  out  1  request to the controller.
- `s_we`  out  1  write to the controller.
- `s_ack`  in  1  acknowledge from the controller.
- `s_sel`  out  4  byte enables to the controller.
- `s_di`  out  32  write data to the controller.
- `s_do`  in  32  read data from the controller.

## Operation
- State register with three states: IDLE, ADDR, DATA. A 2-bit `owner` register and a 2-bit `last` register (last granted master) accompany it.
- IDLE:
  - If any `mN_stb` = 1, select the first requester scanning `last+1, last+2, last+3, last` (mod 4).
  - Latch that master's index into `owner`, its `mN_adr` into `s_adr` and its `mN_we` into `s_we`.
  - Set `last` to the selected index and go to ADDR.
- ADDR:
  - `s_stb` = 1, decoded from the state register.
  - `m[owner]_ack` = `s_ack`; all other `mN_ack` = 0.
  - On `s_ack` = 1, load the beat counter with 3 and go to DATA.
  - If `m[owner]_stb` drops before ack (protocol violation), return to IDLE without acking; `last` is unchanged by the abort.
- DATA: decrement the beat counter each cycle. When the counter is 1 and decrements, go to IDLE, so DATA lasts exactly 3 cycles.
- `s_di` and `s_sel` = `m[owner]_di` and `m[owner]_sel` in every state. This covers the ack cycle plus the 3 DATA cycles, i.e. write beats 0..3.
- Reads: `m_do` = `s_do` combinationally. The arbiter does no read-data steering; each master samples per its own FML timing after its ack.
- A new grant is never issued while in ADDR or DATA. Requests arriving then wait and are arbitrated in the next IDLE cycle.
- Reset (asynchronous, any state, including mid-burst):
  - state = IDLE, `owner` = 0, `last` = 3 (so master 0 has first priority), counter = 0.
  - `s_adr` = 0, `s_we` = 0, hence `s_stb` = 0 and all `mN_ack` = 0.
  - Any in-flight burst is abandoned; the controller is reset by the same event.

## Timing
- Grant latency: `mN_stb` rising in IDLE at cycle T gives `s_stb` = 1 at T+1.
- Ack pass-through is combinational: `mN_ack` is high in the same cycle as `s_ack`.
- Write data: owner drives beat 0 on the ack cycle A and beats 1..3 on A+1..A+3. These are muxed to `s_di`/`s_sel` with no added latency.
- Return to IDLE at A+4; earliest next `s_stb` at A+5. Minimum per-burst overhead is 2 cycles beyond the controller's own latency.
- `s_stb` is high for at least 1 cycle and drops in the cycle after `s_ack`.
- Fairness: with all four masters requesting continuously, grants rotate 0,1,2,3,0,…; no master waits more than 3 bursts.

## Test plan
- After reset, m2 alone requests a write with adr=0x0001000, di beats 0xA0..0xA3, sel=0xF -> `s_stb` one cycle later with `s_adr`=0x0001000, `s_we`=1. Controller acks after 4 cycles -> `m2_ack` pulses once; `s_di` shows 0xA0..0xA3 on A..A+3; `m0/1/3_ack` stay 0.
- m0..m3 all request reads continuously -> grant order 0,1,2,3,0,1. Each burst: exactly one `mN_ack` pulse; `s_adr` matches the owner's address.
- m1 and m3 request in the same IDLE cycle with `last`=1 -> m3 is granted first, then m1.
- m0 bursting; m1 raises `stb` during DATA -> m1 is not granted before IDLE; `s_stb` for m1 appears 2 cycles after m0's last beat.
- m1 owns the port in ADDR and drops `mN_stb` before `s_ack` -> state returns to IDLE, no ack to m1, `s_stb` low next cycle.
- `sys_rst_n` asserted during DATA beat 2 -> all `mN_ack`, `s_stb`, `s_we` and `s_adr` read 0 immediately. After release, a lone m3 request is granted normally.
